// File: rtl/dvs_step_ctrl.sv
// DVS step controller: ramps dvs_data toward a requested code in bounded steps,
// waiting for the buck's synchronized settle acknowledge after each step.
module dvs_step_ctrl #(
  parameter int unsigned CODE_W         = 8,
  parameter int unsigned STEP           = 4,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  input  logic              dvs_done_ana,
  output logic [CODE_W-1:0] dvs_data,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > BLANK_CYCLES) ? TIMEOUT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CODE_W-1:0] STEP_C       = CODE_W'(STEP);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP_CALC,
    ST_BLANK,
    ST_WAIT,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  target_q, target_d;
  logic [CODE_W-1:0]  data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_d;
  logic               busy_d, done_d, ready_d;
  logic               settled;
  logic [CODE_W-1:0]  diff, step_amt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               done_s;

  // Settle acknowledge crosses in from the analog domain; only the last stage is used.
  assign done_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      dvs_data  <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      req_ready <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], dvs_done_ana};
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      dvs_data  <= data_d;
      en        <= enable;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      req_ready <= ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    data_d   = dvs_data;
    cnt_d    = cnt_q;
    err_d    = err;
    settled  = 1'b0;
    diff     = '0;
    step_amt = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          target_d = req_code;
          err_d    = ERR_NONE;
          state_d  = (req_code == dvs_data) ? ST_FINISH : ST_STEP_CALC;
        end
      end
      ST_STEP_CALC: begin
        // Step is clamped so the ramp lands exactly on the target without wrapping.
        if (dvs_data < target_q) begin
          diff     = target_q - dvs_data;
          step_amt = (diff > STEP_C) ? STEP_C : diff;
          data_d   = dvs_data + step_amt;
        end else if (dvs_data > target_q) begin
          diff     = dvs_data - target_q;
          step_amt = (diff > STEP_C) ? STEP_C : diff;
          data_d   = dvs_data - step_amt;
        end
        cnt_d   = BLANK_LAST;
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        // Code 0 is never acknowledged by the converter, so it settles after blanking.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (dvs_data == '0) begin
          settled = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          settled = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (settled) begin
      state_d = (dvs_data == target_q) ? ST_FINISH : ST_STEP_CALC;
    end

    // Losing enable mid-ramp wins over settle/timeout; FINISH is excluded so done and abort never coincide.
    if (!enable && (state_q inside {ST_STEP_CALC, ST_BLANK, ST_WAIT})) begin
      state_d = ST_IDLE;
      data_d  = dvs_data;
      err_d   = ERR_ABORT;
    end

    busy_d  = state_d inside {ST_STEP_CALC, ST_BLANK, ST_WAIT};
    done_d  = (state_d == ST_FINISH);
    ready_d = (state_d == ST_IDLE) && enable;
  end

endmodule
